// File: rtl/gyruss_hpf_dcblock_if.sv
// Sample-stream bundle for the DC-blocking high-pass stage.
// The producer/consumer side drives 'in' and watches 'out'/'out_valid'.
interface gyruss_hpf_dcblock_if;
    logic signed [15:0] in;
    logic signed [15:0] out;
    logic               out_valid;

    modport master (
        output in,
        input  out,
        input  out_valid
    );

    modport slave (
        input  in,
        output out,
        output out_valid
    );
endinterface

// File: rtl/gyruss_hpf_dcblock.sv
// First-order IIR DC blocker: y[n] = x[n] - x[n-1] + A*y[n-1] (A in unsigned Q15).
// A free-running divider produces one sample edge every DIV clocks; a 4-state
// sequencer shares one multiplier and finishes well before the next edge.
module gyruss_hpf_dcblock #(
    parameter int unsigned DIV    = 220,
    parameter int unsigned A_COEF = 32440
) (
    input  logic                  clk,
    input  logic                  reset,
    gyruss_hpf_dcblock_if.slave   sb
);

    localparam int unsigned CntW = 10;
    localparam logic [CntW-1:0]    CntLast = CntW'(DIV - 1);
    localparam logic signed [16:0] ACoef   = 17'(A_COEF);
    localparam logic signed [17:0] SatHi   = 18'sd32767;
    localparam logic signed [17:0] SatLo   = -18'sd32768;

    typedef enum logic [1:0] {StIdle, StMul, StSum, StSat} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]    cnt_q;
    logic               strobe;

    logic signed [15:0] x_cur_q;
    logic signed [15:0] x_prev_q;
    logic signed [15:0] y_prev_q;
    logic signed [31:0] prod_q;
    logic signed [16:0] diff_q;
    logic signed [17:0] sum_q;
    logic signed [15:0] out_q;
    logic               valid_q;

    logic               ld_x;
    logic               do_mul;
    logic               do_sum;
    logic               do_sat;
    logic signed [15:0] sat_val;

    assign strobe = (cnt_q == CntLast);

    // Sample divider: counts 0..DIV-1 regardless of sequencer state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (strobe) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next-state: wait for the sample edge, then MUL -> SUM -> SAT -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (strobe) state_d = StMul;
            StMul:  state_d = StSum;
            StSum:  state_d = StSat;
            StSat:  state_d = StIdle;
        endcase
    end

    // Sequencer outputs: one datapath enable per state.
    always_comb begin
        ld_x   = 1'b0;
        do_mul = 1'b0;
        do_sum = 1'b0;
        do_sat = 1'b0;
        unique case (state_q)
            StIdle: ld_x   = strobe;
            StMul:  do_mul = 1'b1;
            StSum:  do_sum = 1'b1;
            StSat:  do_sat = 1'b1;
        endcase
    end

    // Clamp the 18-bit sum into the 16-bit output range.
    always_comb begin
        if (sum_q > SatHi) begin
            sat_val = 16'sh7fff;
        end else if (sum_q < SatLo) begin
            sat_val = 16'sh8000;
        end else begin
            sat_val = sum_q[15:0];
        end
    end

    // Datapath registers; y_prev keeps the clamped value so the loop cannot wind up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_cur_q  <= '0;
            x_prev_q <= '0;
            y_prev_q <= '0;
            prod_q   <= '0;
            diff_q   <= '0;
            sum_q    <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= do_sat;
            if (ld_x) begin
                x_cur_q <= sb.in;
            end
            if (do_mul) begin
                prod_q <= 32'(ACoef) * 32'(y_prev_q);
                diff_q <= 17'(x_cur_q) - 17'(x_prev_q);
            end
            if (do_sum) begin
                // Arithmetic shift floors toward -inf; result fits in 18 bits.
                sum_q <= 18'(32'(diff_q) + (prod_q >>> 15));
            end
            if (do_sat) begin
                out_q    <= sat_val;
                y_prev_q <= sat_val;
                x_prev_q <= x_cur_q;
            end
        end
    end

    assign sb.out       = out_q;
    assign sb.out_valid = valid_q;

endmodule

// File: tb/tb_gyruss_hpf_dcblock.sv
// Directed bench for the DC-blocking high-pass stage (short divider for speed).
module tb_gyruss_hpf_dcblock;

    localparam int DIV    = 8;
    localparam int A_COEF = 32440;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    gyruss_hpf_dcblock_if bus();

    gyruss_hpf_dcblock #(
        .DIV    (DIV),
        .A_COEF (A_COEF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference recurrence with floor rounding and output clamp.
    function automatic int hpf(input int x, input int xp, input int yp);
        int s;
        s = (x - xp) + ((A_COEF * yp) >>> 15);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Advance edge by edge until out_valid is seen; n counts edges consumed.
    task automatic wait_valid(input int maxc, output int n, output bit got);
        got = 1'b0;
        n   = 0;
        while (!got && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.out_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        int  n;
        bit  got;
        bit  bad;
        bus.in = 16'sd1234;
        reset  = 1'b0;
        bad    = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (!bad) begin
                vectors++;
                if (bus.out !== 16'sd0 || bus.out_valid !== 1'b0) begin
                    miscompares++;
                    bad = 1'b1;
                    $display("FAIL reset_hold: cycle %0d got out=%0d valid=%b, want out=0 valid=0",
                             i, bus.out, bus.out_valid);
                end
            end
        end
        reset = 1'b1;
        wait_valid(4 * DIV, n, got);
        vectors++;
        if (!got || n !== DIV + 3) begin
            miscompares++;
            $display("FAIL reset_first_valid: got %0d clks (seen=%b), want %0d", n, got, DIV + 3);
        end
        vectors++;
        if (bus.out !== 16'sd1234) begin
            miscompares++;
            $display("FAIL reset_first_out: got %0d, want 1234", bus.out);
        end
    endtask

    task automatic test_dc_step();
        int  n;
        bit  got;
        int  yexp;
        int  prev;
        int  zeros;
        int  hand[4];
        hand[0] = 10000; hand[1] = 9899; hand[2] = 9799; hand[3] = 9700;
        bus.in = 16'sd10000;
        do_reset();
        yexp  = 0;
        prev  = 10000;
        zeros = 0;
        for (int k = 0; k < 2000 && zeros < 5; k++) begin
            wait_valid(2 * DIV, n, got);
            yexp = hpf(10000, (k == 0) ? 0 : 10000, yexp);
            vectors++;
            if (!got) begin
                miscompares++;
                $display("FAIL dc_step_timeout: sample %0d got no out_valid, want one", k);
                return;
            end
            if (k < 4) begin
                vectors++;
                if (int'(bus.out) !== hand[k]) begin
                    miscompares++;
                    $display("FAIL dc_step_hand[%0d]: got %0d, want %0d", k, bus.out, hand[k]);
                end
            end
            vectors++;
            if (int'(bus.out) !== yexp || int'(bus.out) > prev) begin
                miscompares++;
                $display("FAIL dc_step[%0d]: got %0d, want %0d (prev %0d)", k, bus.out, yexp, prev);
                return;
            end
            prev = int'(bus.out);
            if (yexp == 0) zeros++;
        end
        vectors++;
        if (zeros < 5) begin
            miscompares++;
            $display("FAIL dc_step_settle: got %0d zero samples, want 5", zeros);
        end
    endtask

    task automatic test_saturation();
        int n;
        bit got;
        bus.in = -16'sd32768;
        do_reset();
        wait_valid(2 * DIV, n, got);
        vectors++;
        if (!got || bus.out !== -16'sd32768) begin
            miscompares++;
            $display("FAIL sat_neg: got %0d, want -32768", bus.out);
        end
        repeat (20) wait_valid(2 * DIV, n, got);
        bus.in = 16'sd32767;
        wait_valid(2 * DIV, n, got);
        vectors++;
        if (!got || bus.out !== 16'sd32767) begin
            miscompares++;
            $display("FAIL sat_step: got %0d, want 32767", bus.out);
        end
        wait_valid(2 * DIV, n, got);
        vectors++;
        if (!got || bus.out !== 16'sd32439) begin
            miscompares++;
            $display("FAIL sat_next: got %0d, want 32439", bus.out);
        end
    endtask

    task automatic test_impulse();
        int n;
        bit got;
        int want[3];
        want[0] = 8000; want[1] = -81; want[2] = -81;
        bus.in = 16'sd0;
        do_reset();
        wait_valid(2 * DIV, n, got);
        vectors++;
        if (!got || bus.out !== 16'sd0) begin
            miscompares++;
            $display("FAIL impulse_pre: got %0d, want 0", bus.out);
        end
        bus.in = 16'sd8000;
        for (int k = 0; k < 3; k++) begin
            wait_valid(2 * DIV, n, got);
            bus.in = 16'sd0;
            vectors++;
            if (!got || int'(bus.out) !== want[k]) begin
                miscompares++;
                $display("FAIL impulse[%0d]: got %0d, want %0d", k, bus.out, want[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        bit got;
        bit bad;
        bus.in = 16'sd5000;
        do_reset();
        // Edge DIV is the sample edge; after edge DIV+1 the sequencer sits in SUM.
        repeat (DIV + 1) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.out !== 16'sd0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_clear: got out=%0d valid=%b, want 0/0", bus.out, bus.out_valid);
        end
        reset = 1'b1;
        bad = 1'b0;
        got = 1'b0;
        n   = 0;
        while (!got && n < 4 * DIV) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.out_valid === 1'b1) got = 1'b1;
            else if (bus.out !== 16'sd0) bad = 1'b1;
        end
        vectors++;
        if (bad || !got || n !== DIV + 3) begin
            miscompares++;
            $display("FAIL midreset_restart: got %0d clks (seen=%b, outdirty=%b), want %0d",
                     n, got, bad, DIV + 3);
        end
        vectors++;
        if (bus.out !== 16'sd5000) begin
            miscompares++;
            $display("FAIL midreset_out: got %0d, want 5000", bus.out);
        end
    endtask

    task automatic test_timing();
        int   cyc;
        int   last;
        int   pulses;
        bit   pv;
        logic signed [15:0] hold;
        bus.in = 16'sd300;
        do_reset();
        last   = -1;
        pulses = 0;
        pv     = 1'b0;
        hold   = '0;
        for (cyc = 0; cyc < 12 * DIV + 20 && pulses < 11; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                vectors++;
                if (pv) begin
                    miscompares++;
                    $display("FAIL timing_width: cycle %0d got 2-clk pulse, want 1", cyc);
                end
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last !== DIV) begin
                        miscompares++;
                        $display("FAIL timing_gap: got %0d, want %0d", cyc - last, DIV);
                    end
                end
                last = cyc;
                hold = bus.out;
                pulses++;
                bus.in = 16'(pulses * 1500 - 7000);
                pv = 1'b1;
            end else begin
                if (last >= 0) begin
                    vectors++;
                    if (bus.out !== hold) begin
                        miscompares++;
                        $display("FAIL timing_hold: cycle %0d got %0d, want %0d", cyc, bus.out, hold);
                    end
                end
                pv = 1'b0;
            end
        end
        vectors++;
        if (pulses !== 11) begin
            miscompares++;
            $display("FAIL timing_count: got %0d pulses, want 11", pulses);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.in      = 16'sd0;
        test_reset();
        test_dc_step();
        test_saturation();
        test_impulse();
        test_mid_reset();
        test_timing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
